// File: rtl/ycr_dmem_sram_resp_if.sv
// Core data-memory request/response bus (req / req_ack / resp) between an initiator and a target.
`ifndef YCR_DMEM_AWIDTH
`define YCR_DMEM_AWIDTH 32
`endif
`ifndef YCR_DMEM_DWIDTH
`define YCR_DMEM_DWIDTH 32
`endif

interface ycr_dmem_sram_resp_if;
   logic                        dmem_req_ack;
   logic                        dmem_req;
   logic                        dmem_cmd;
   logic [1:0]                  dmem_width;
   logic [`YCR_DMEM_AWIDTH-1:0] dmem_addr;
   logic [`YCR_DMEM_DWIDTH-1:0] dmem_wdata;
   logic [`YCR_DMEM_DWIDTH-1:0] dmem_rdata;
   logic [1:0]                  dmem_resp;

   modport master (
      output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
      input  dmem_req_ack, dmem_rdata, dmem_resp
   );

   modport slave (
      input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
      output dmem_req_ack, dmem_rdata, dmem_resp
   );
endinterface

// File: rtl/ycr_dmem_sram_resp.sv
// Data-memory protocol target backed by a single-port synchronous SRAM, one transaction outstanding.
// Define YCR_DMEM_RESP_OREG_EN to register dmem_rdata/dmem_resp (latency 2, one transaction per two cycles).
`ifndef YCR_DMEM_AWIDTH
`define YCR_DMEM_AWIDTH 32
`endif
`ifndef YCR_DMEM_DWIDTH
`define YCR_DMEM_DWIDTH 32
`endif

module ycr_dmem_sram_resp #(
   parameter int SRAM_AWIDTH = 9
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ycr_dmem_sram_resp_if.slave    dmem,
   input  logic                   sram_gnt,
   output logic                   sram_ce,
   output logic                   sram_we,
   output logic [3:0]             sram_be,
   output logic [SRAM_AWIDTH-1:0] sram_addr,
   output logic [31:0]            sram_wdata,
   input  logic [31:0]            sram_rdata
);

   localparam logic [1:0] RESP_NOTRDY = 2'b00;
   localparam logic [1:0] RESP_OK     = 2'b01;
   localparam logic [1:0] RESP_ER     = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1
`ifdef YCR_DMEM_RESP_OREG_EN
      , WAIT = 2'd2
`endif
   } state_t;

   function automatic logic req_err(input logic [1:0] width, input logic [1:0] ofs);
      case (width)
         2'd0:    return 1'b0;
         2'd1:    return ofs[0];
         2'd2:    return ofs != 2'd0;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_be(input logic [1:0] width, input logic [1:0] ofs);
      case (width)
         2'd0:    return 4'b0001 << ofs;
         2'd1:    return 4'b0011 << ofs;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] align_rdata(input logic [31:0] raw, input logic [1:0] width,
                                               input logic [1:0] ofs);
      logic [31:0] sh;
      sh = raw >> {ofs, 3'b000};
      case (width)
         2'd0:    return {24'h0, sh[7:0]};
         2'd1:    return {16'h0, sh[15:0]};
         default: return sh;
      endcase
   endfunction

   state_t      state, state_next;
   logic        ack_ok, accept;
   logic [1:0]  ofs_p0;
   logic        err_p0;
   logic [1:0]  ofs_p1, width_p1;
   logic        cmd_p1, err_p1;
   logic [1:0]  resp_p1;
   logic [31:0] rdata_p1;
   logic        unused_addr_hi;

   // Stage 0: accept decode and combinational SRAM strobe
   assign ofs_p0 = dmem.dmem_addr[1:0];
   assign err_p0 = req_err(dmem.dmem_width, ofs_p0);
`ifdef YCR_DMEM_RESP_OREG_EN
   assign ack_ok = (state != WAIT);
`else
   assign ack_ok = (state == IDLE) || (state == DATA);
`endif
   assign dmem.dmem_req_ack = rst_n & sram_gnt & ack_ok;
   assign accept            = dmem.dmem_req & dmem.dmem_req_ack;

   assign sram_ce    = accept & ~err_p0;
   assign sram_we    = sram_ce & dmem.dmem_cmd;
   assign sram_be    = sram_ce ? lane_be(dmem.dmem_width, ofs_p0) : 4'b0000;
   assign sram_addr  = rst_n ? dmem.dmem_addr[SRAM_AWIDTH+1:2] : '0;
   assign sram_wdata = rst_n ? (dmem.dmem_wdata << {ofs_p0, 3'b000}) : 32'h0;
   assign unused_addr_hi = ^dmem.dmem_addr[`YCR_DMEM_AWIDTH-1:SRAM_AWIDTH+2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = IDLE;
      case (state)
`ifdef YCR_DMEM_RESP_OREG_EN
         IDLE, DATA: if (accept) state_next = WAIT;
         WAIT:       state_next = DATA;
`else
         IDLE, DATA: if (accept) state_next = DATA;
`endif
         default:    state_next = IDLE;
      endcase
   end

   // Stage 1: request info captured on accept, SRAM read data arrives
   always_ff @(posedge clk) begin
      if (accept) begin
         ofs_p1   <= ofs_p0;
         width_p1 <= dmem.dmem_width;
         cmd_p1   <= dmem.dmem_cmd;
         err_p1   <= err_p0;
      end
   end

   assign resp_p1  = err_p1 ? RESP_ER : RESP_OK;
   assign rdata_p1 = (cmd_p1 | err_p1) ? 32'h0 : align_rdata(sram_rdata, width_p1, ofs_p1);

`ifdef YCR_DMEM_RESP_OREG_EN
   logic [1:0]  resp_p2;
   logic [31:0] rdata_p2;

   // Stage 2: registered response, valid for the single DATA cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_p2  <= RESP_NOTRDY;
         rdata_p2 <= 32'h0;
      end else if (state == WAIT) begin
         resp_p2  <= resp_p1;
         rdata_p2 <= rdata_p1;
      end else begin
         resp_p2  <= RESP_NOTRDY;
         rdata_p2 <= 32'h0;
      end
   end

   assign dmem.dmem_resp  = resp_p2;
   assign dmem.dmem_rdata = rdata_p2;
`else
   assign dmem.dmem_resp  = (state == DATA) ? resp_p1 : RESP_NOTRDY;
   assign dmem.dmem_rdata = (state == DATA) ? rdata_p1 : 32'h0;
`endif

endmodule

// File: tb/tb_ycr_dmem_sram_resp.sv
// Bench for ycr_dmem_sram_resp (default build): vector table, random traffic vs byte-array model, corner sequences.
`timescale 1ns/1ps
module tb_ycr_dmem_sram_resp;

   typedef struct {
      logic        cmd;
      logic [1:0]  width;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_ce;
      logic [3:0]  exp_be;
      logic [8:0]  exp_saddr;
      logic [31:0] exp_swdata;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sram_gnt;
   logic        sram_ce, sram_we;
   logic [3:0]  sram_be;
   logic [8:0]  sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        mem_clr;

   logic [31:0] sram_mem [512];
   logic [7:0]  ref_mem  [2048];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ycr_dmem_sram_resp_if bus ();

   ycr_dmem_sram_resp #(.SRAM_AWIDTH(9)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dmem       (bus),
      .sram_gnt   (sram_gnt),
      .sram_ce    (sram_ce),
      .sram_we    (sram_we),
      .sram_be    (sram_be),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   // Synchronous single-port SRAM environment
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 512; i++) sram_mem[i] <= 32'h0;
         sram_rdata <= 32'h0;
      end else if (sram_ce) begin
         if (sram_we) begin
            for (int i = 0; i < 4; i++)
               if (sram_be[i]) sram_mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
         end else begin
            sram_rdata <= sram_mem[sram_addr];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: byte-addressed memory over the 2 KiB window
   function automatic int nbytes(input logic [1:0] w);
      return 1 << w;
   endfunction

   function automatic logic model_err(input logic [1:0] w, input logic [31:0] a);
      if (w == 2'd3) return 1'b1;
      return (int'(a[1:0]) % nbytes(w)) != 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] w, input logic [31:0] a);
      logic [3:0] be;
      be = 4'b0;
      for (int i = 0; i < nbytes(w); i++) be[int'(a[1:0]) + i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] model_read(input logic [1:0] w, input logic [31:0] a);
      logic [31:0] v;
      int base;
      v = 32'h0;
      base = int'(a[10:0]);
      for (int i = 0; i < nbytes(w); i++) v[8*i +: 8] = ref_mem[base + i];
      return v;
   endfunction

   task automatic model_write(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
      int base;
      base = int'(a[10:0]);
      for (int i = 0; i < nbytes(w); i++) ref_mem[base + i] = d[8*i +: 8];
   endtask

   function automatic vec_t model_vec(input logic c, input logic [1:0] w, input logic [31:0] a,
                                      input logic [31:0] d);
      vec_t v;
      logic e;
      e = model_err(w, a);
      v.cmd        = c;
      v.width      = w;
      v.addr       = a;
      v.wdata      = d;
      v.exp_ce     = !e;
      v.exp_be     = e ? 4'b0 : model_be(w, a);
      v.exp_saddr  = a[10:2];
      v.exp_swdata = d << (8 * int'(a[1:0]));
      v.exp_resp   = e ? 2'b10 : 2'b01;
      v.exp_rdata  = (e || c) ? 32'h0 : model_read(w, a);
      return v;
   endfunction

   task automatic drive_req(input logic c, input logic [1:0] w, input logic [31:0] a,
                            input logic [31:0] d);
      bus.dmem_req   = 1'b1;
      bus.dmem_cmd   = c;
      bus.dmem_width = w;
      bus.dmem_addr  = a;
      bus.dmem_wdata = d;
   endtask

   // One isolated transaction: starts just after a rising edge, ends just after one
   task automatic xact(input vec_t v, input string tag);
      drive_req(v.cmd, v.width, v.addr, v.wdata);
      @(negedge clk);
      chk({tag, " ack"}, 32'(bus.dmem_req_ack), 32'd1);
      chk({tag, " sram_ce"}, 32'(sram_ce), 32'(v.exp_ce));
      chk({tag, " sram_we"}, 32'(sram_we), 32'(v.exp_ce & v.cmd));
      if (v.exp_ce) begin
         chk({tag, " sram_be"}, 32'(sram_be), 32'(v.exp_be));
         chk({tag, " sram_addr"}, 32'(sram_addr), 32'(v.exp_saddr));
         if (v.cmd) chk({tag, " sram_wdata"}, sram_wdata, v.exp_swdata);
      end
      @(posedge clk); #1;
      bus.dmem_req = 1'b0;
      if (v.exp_ce && v.cmd) model_write(v.width, v.addr, v.wdata);
      @(negedge clk);
      chk({tag, " resp"}, 32'(bus.dmem_resp), 32'(v.exp_resp));
      chk({tag, " rdata"}, bus.dmem_rdata, v.exp_rdata);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        vecs [13];
      vec_t        v;
      logic [31:0] b2b_addr [8];
      logic [31:0] b2b_exp  [8];

      vecs[0]  = '{1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 4'b1111, 9'd4, 32'hDEAD_BEEF, 2'b01, 32'h0};
      vecs[1]  = '{1'b0, 2'd2, 32'h0000_0010, 32'h0,         1'b1, 4'b1111, 9'd4, 32'h0,         2'b01, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 2'd0, 32'h0000_0013, 32'h0000_00A5, 1'b1, 4'b1000, 9'd4, 32'hA500_0000, 2'b01, 32'h0};
      vecs[3]  = '{1'b0, 2'd0, 32'h0000_0013, 32'h0,         1'b1, 4'b1000, 9'd4, 32'h0,         2'b01, 32'h0000_00A5};
      vecs[4]  = '{1'b0, 2'd1, 32'h0000_0021, 32'h0,         1'b0, 4'b0000, 9'd8, 32'h0,         2'b10, 32'h0};
      vecs[5]  = '{1'b0, 2'd3, 32'h0000_0040, 32'h0,         1'b0, 4'b0000, 9'd16, 32'h0,        2'b10, 32'h0};
      vecs[6]  = '{1'b0, 2'd2, 32'h0000_0010, 32'h0,         1'b1, 4'b1111, 9'd4, 32'h0,         2'b01, 32'hA5AD_BEEF};
      vecs[7]  = '{1'b0, 2'd1, 32'h0000_0012, 32'h0,         1'b1, 4'b1100, 9'd4, 32'h0,         2'b01, 32'h0000_A5AD};
      vecs[8]  = '{1'b1, 2'd1, 32'h0000_0022, 32'h1234_CAFE, 1'b1, 4'b1100, 9'd8, 32'hCAFE_0000, 2'b01, 32'h0};
      vecs[9]  = '{1'b0, 2'd2, 32'h0000_0020, 32'h0,         1'b1, 4'b1111, 9'd8, 32'h0,         2'b01, 32'hCAFE_0000};
      vecs[10] = '{1'b1, 2'd2, 32'h0000_0022, 32'hFFFF_FFFF, 1'b0, 4'b0000, 9'd8, 32'h0,         2'b10, 32'h0};
      vecs[11] = '{1'b0, 2'd2, 32'h0000_0020, 32'h0,         1'b1, 4'b1111, 9'd8, 32'h0,         2'b01, 32'hCAFE_0000};
      vecs[12] = '{1'b0, 2'd0, 32'h0000_0822, 32'h0,         1'b1, 4'b0100, 9'd8, 32'h0,         2'b01, 32'h0000_00FE};

      for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h0;
      mem_clr  = 1'b1;
      rst_n    = 1'b0;
      sram_gnt = 1'b1;
      drive_req(1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF);

      // Reset: request and grant present, everything must be held at zero
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset ack", 32'(bus.dmem_req_ack), 32'd0);
      chk("reset sram_ce", 32'(sram_ce), 32'd0);
      chk("reset sram_we", 32'(sram_we), 32'd0);
      chk("reset sram_be", 32'(sram_be), 32'd0);
      chk("reset sram_addr", 32'(sram_addr), 32'd0);
      chk("reset sram_wdata", sram_wdata, 32'd0);
      chk("reset resp", 32'(bus.dmem_resp), 32'd0);
      chk("reset rdata", bus.dmem_rdata, 32'd0);
      @(posedge clk); #1;
      mem_clr      = 1'b0;
      bus.dmem_req = 1'b0;
      rst_n        = 1'b1;
      @(negedge clk);
      chk("idle resp", 32'(bus.dmem_resp), 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         xact(vecs[i], $sformatf("vec%0d", i));
         if (vecs[i].exp_ce && vecs[i].cmd) begin
            // table writes were already applied to the model inside xact
         end
      end

      for (int i = 0; i < 40; i++) begin
         logic        c;
         logic [1:0]  w;
         logic [31:0] a;
         c = 1'($urandom_range(0, 1));
         w = 2'($urandom_range(0, 3));
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         v = model_vec(c, w, a, $urandom);
         xact(v, $sformatf("rnd%0d", i));
      end

      // Back-to-back word reads with the request held high
      for (int k = 0; k < 8; k++) begin
         b2b_addr[k] = ($urandom & 32'hFFFF_F800) | (32'h100 + 32'(4 * k));
         b2b_exp[k]  = model_read(2'd2, b2b_addr[k]);
      end
      drive_req(1'b0, 2'd2, b2b_addr[0], 32'h0);
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         if (k < 8) begin
            chk($sformatf("b2b%0d ack", k), 32'(bus.dmem_req_ack), 32'd1);
            chk($sformatf("b2b%0d sram_ce", k), 32'(sram_ce), 32'd1);
            chk($sformatf("b2b%0d sram_addr", k), 32'(sram_addr), 32'(b2b_addr[k][10:2]));
         end
         if (k > 0) begin
            chk($sformatf("b2b%0d resp", k - 1), 32'(bus.dmem_resp), 32'd1);
            chk($sformatf("b2b%0d rdata", k - 1), bus.dmem_rdata, b2b_exp[k - 1]);
         end
         @(posedge clk); #1;
         if (k < 7) bus.dmem_addr = b2b_addr[k + 1];
         else       bus.dmem_req  = 1'b0;
      end

      // Grant stall in IDLE: request held, accepted on the first granted cycle
      v = model_vec(1'b0, 2'd2, 32'h10, 32'h0);
      sram_gnt = 1'b0;
      drive_req(1'b0, 2'd2, 32'h10, 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("stall%0d ack", k), 32'(bus.dmem_req_ack), 32'd0);
         chk($sformatf("stall%0d sram_ce", k), 32'(sram_ce), 32'd0);
         chk($sformatf("stall%0d resp", k), 32'(bus.dmem_resp), 32'd0);
         @(posedge clk); #1;
      end
      sram_gnt = 1'b1;
      @(negedge clk);
      chk("stall_go ack", 32'(bus.dmem_req_ack), 32'd1);
      chk("stall_go sram_ce", 32'(sram_ce), 32'd1);
      @(posedge clk); #1;
      bus.dmem_req = 1'b0;
      @(negedge clk);
      chk("stall_go resp", 32'(bus.dmem_resp), 32'd1);
      chk("stall_go rdata", bus.dmem_rdata, v.exp_rdata);
      @(posedge clk); #1;

      // Grant drops while a response is due: response still delivered, no new accept
      drive_req(1'b0, 2'd2, 32'h10, 32'h0);
      @(negedge clk);
      chk("gdrop ack", 32'(bus.dmem_req_ack), 32'd1);
      @(posedge clk); #1;
      sram_gnt = 1'b0;
      @(negedge clk);
      chk("gdrop resp", 32'(bus.dmem_resp), 32'd1);
      chk("gdrop rdata", bus.dmem_rdata, v.exp_rdata);
      chk("gdrop ack_low", 32'(bus.dmem_req_ack), 32'd0);
      chk("gdrop sram_ce", 32'(sram_ce), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("gdrop idle_resp", 32'(bus.dmem_resp), 32'd0);
      @(posedge clk); #1;
      bus.dmem_req = 1'b0;
      sram_gnt     = 1'b1;

      // Reset in the cycle after an accepted write
      v = model_vec(1'b1, 2'd2, 32'h80, 32'h1357_9BDF);
      drive_req(1'b1, 2'd2, 32'h80, 32'h1357_9BDF);
      @(negedge clk);
      chk("rst_acc ack", 32'(bus.dmem_req_ack), 32'd1);
      chk("rst_acc sram_ce", 32'(sram_ce), 32'd1);
      @(posedge clk); #1;
      bus.dmem_req = 1'b0;
      rst_n        = 1'b0;
      model_write(v.width, v.addr, v.wdata);
      @(negedge clk);
      chk("rst_mid resp", 32'(bus.dmem_resp), 32'd0);
      chk("rst_mid rdata", bus.dmem_rdata, 32'd0);
      chk("rst_mid sram_ce", 32'(sram_ce), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rel resp", 32'(bus.dmem_resp), 32'd0);
      @(posedge clk); #1;
      xact(model_vec(1'b0, 2'd2, 32'h80, 32'h0), "rst_rd");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
